// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: ramps count from lo to hi and back to lo for a
// programmable number of passes, then pulses done. lo/hi/passes are latched
// on an accepted start so the sweep is immune to later input changes.
//
// state | meaning
// IDLE  | waiting for start; count/up_down hold
// UP    | incrementing toward latched hi
// DOWN  | decrementing toward latched lo
// DONE  | one-cycle completion state, done pulse high
module updown_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  output logic [WIDTH-1:0]  count,
  output logic              up_down,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    lo_q;
  logic [WIDTH-1:0]    hi_q;
  logic [PASS_W-1:0]   passes_q;
  logic [PASS_W-1:0]   pass_cnt;

  logic [WIDTH-1:0]    count_inc;
  logic [WIDTH-1:0]    count_dec;
  logic [PASS_W-1:0]   pass_inc;
  logic                start_ok;

  // Next-value helpers shared by the turn-around compares.
  always_comb begin
    count_inc = count + {{(WIDTH-1){1'b0}}, 1'b1};
    count_dec = count - {{(WIDTH-1){1'b0}}, 1'b1};
    pass_inc  = pass_cnt + {{(PASS_W-1){1'b0}}, 1'b1};
    start_ok  = (lo < hi) && (passes != '0);
  end

  // Sweep FSM with all outputs registered; done/err default low so they pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      up_down  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      passes_q <= '0;
      pass_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // abort outranks start even though there is no sweep to stop
          if (start && !abort) begin
            if (start_ok) begin
              lo_q     <= lo;
              hi_q     <= hi;
              passes_q <= passes;
              pass_cnt <= '0;
              count    <= lo;
              up_down  <= 1'b1;
              busy     <= 1'b1;
              state    <= UP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        UP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count_inc;
            if (count_inc == hi_q) begin
              up_down <= 1'b0;
              state   <= DOWN;
            end
          end
        end
        DOWN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count_dec;
            if (count_dec == lo_q) begin
              pass_cnt <= pass_inc;
              if (pass_inc == passes_q) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                up_down <= 1'b1;
                state   <= UP;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a queue-based model of the expected output
// sequence is compared every cycle, plus hand-computed literal checks.
module tb_updown_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] passes;
  logic [3:0] count;
  logic       up_down;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  updown_sweep_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .passes(passes),
    .count(count), .up_down(up_down), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int c;
    bit ud;
    bit b;
    bit d;
  } entry_t;

  entry_t q[$];
  int exp_count;
  bit exp_ud, exp_busy, exp_done, exp_err;

  // Whole sweep written out as the list of per-cycle outputs.
  function automatic void build(input int l, input int h, input int p);
    entry_t e;
    q.delete();
    e = '{c: l, ud: 1, b: 1, d: 0};
    q.push_back(e);
    for (int k = 0; k < p; k++) begin
      for (int v = l + 1; v <= h; v++) begin
        e = '{c: v, ud: (v != h), b: 1, d: 0};
        q.push_back(e);
      end
      for (int v = h - 1; v >= l; v--) begin
        if (v == l && k == p - 1) e = '{c: v, ud: 0, b: 0, d: 1};
        else if (v == l)          e = '{c: v, ud: 1, b: 1, d: 0};
        else                      e = '{c: v, ud: 0, b: 1, d: 0};
        q.push_back(e);
      end
    end
  endfunction

  function automatic void apply_front();
    entry_t e;
    e = q.pop_front();
    exp_count = e.c;
    exp_ud    = e.ud;
    exp_busy  = e.b;
    exp_done  = e.d;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      exp_count = 0; exp_ud = 1; exp_busy = 0; exp_done = 0; exp_err = 0;
    end else begin
      exp_err = 0;
      if (q.size() != 0) begin
        if (abort) begin
          q.delete();
          exp_busy = 0;
          exp_done = 0;
        end else begin
          apply_front();
        end
      end else if (exp_done) begin
        exp_done = 0;
      end else if (start && !abort) begin
        if (int'(lo) < int'(hi) && passes != 0) begin
          build(int'(lo), int'(hi), int'(passes));
          apply_front();
        end else begin
          exp_err = 1;
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    check("count",   int'(count),   exp_count);
    check("up_down", int'(up_down), int'(exp_ud));
    check("busy",    int'(busy),    int'(exp_busy));
    check("done",    int'(done),    int'(exp_done));
    check("err",     int'(err),     int'(exp_err));
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input int l, input int h, input int p);
    lo = 4'(l); hi = 4'(h); passes = 4'(p); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_count(input int v, input int lim);
    bit found = 0;
    for (int n = 0; n < lim && !found; n++) begin
      if (int'(count) == v) found = 1;
      else @(negedge clk);
    end
    check("wait_count_timeout", int'(found), 1);
  endtask

  initial begin
    int seq1[7] = '{2, 3, 4, 5, 4, 3, 2};
    int seq4[7] = '{14, 15, 14, 15, 14, 15, 14};
    int nbusy, ndone;

    rst = 1'b0; start = 1'b0; abort = 1'b0; lo = '0; hi = '0; passes = '0;
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_updown", int'(up_down), 1);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single pass; inputs scrambled after acceptance must not matter
    do_start(2, 5, 1);
    lo = 4'd0; hi = 4'd15; passes = 4'd7;
    for (int i = 0; i < 7; i++) begin
      check("sp_count", int'(count), seq1[i]);
      if (i == 3) check("sp_ud_at_hi", int'(up_down), 0);
      if (i == 6) begin
        check("sp_done", int'(done), 1);
        check("sp_busy_end", int'(busy), 0);
      end
      @(negedge clk);
    end
    check("sp_done_clear", int'(done), 0);
    @(negedge clk);

    // full range, two passes
    do_start(0, 15, 2);
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 70; i++) begin
      nbusy += int'(busy);
      ndone += int'(done);
      @(negedge clk);
    end
    check("full_busy_cycles", nbusy, 60);
    check("full_done_pulses", ndone, 1);

    // rejected starts
    do_start(5, 5, 1);
    check("rej1_err", int'(err), 1);
    check("rej1_busy", int'(busy), 0);
    @(negedge clk);
    check("rej1_err_clear", int'(err), 0);
    do_start(1, 4, 0);
    check("rej2_err", int'(err), 1);
    @(negedge clk);
    check("rej2_err_clear", int'(err), 0);

    // abort at the top, with a start held during the sweep
    do_start(3, 9, 1);
    lo = 4'd0; hi = 4'd1; passes = 4'd1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    check("ab_ignore_start", int'(count), 5);
    wait_count(9, 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", int'(busy), 0);
    check("ab_count", int'(count), 9);
    check("ab_ud", int'(up_down), 0);
    check("ab_done", int'(done), 0);
    @(negedge clk);
    // abort beats start in IDLE
    lo = 4'd1; hi = 4'd3; passes = 4'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("ab_start_err", int'(err), 0);
    check("ab_start_busy", int'(busy), 0);
    @(negedge clk);

    // asynchronous reset mid-sweep
    do_start(2, 8, 1);
    wait_count(4, 10);
    #2 rst = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_ud", int'(up_down), 1);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    do_start(1, 3, 1);
    check("post_rst_busy", int'(busy), 1);
    check("post_rst_count", int'(count), 1);
    for (int i = 0; i < 6; i++) @(negedge clk);

    // minimum span, three passes
    do_start(14, 15, 3);
    ndone = 0;
    for (int i = 0; i < 7; i++) begin
      check("min_count", int'(count), seq4[i]);
      ndone += int'(done);
      if (i == 6) check("min_done_last", int'(done), 1);
      @(negedge clk);
    end
    check("min_done_once", ndone, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
